// File: rtl/sopc_bus_ctrl.sv
// ---------------------------------------------------------------------------
// sopc_bus_ctrl
//   Single-master bus controller between a CPU data port and up to NSLV
//   slaves. Slave index = cpu_addr_i[31:28]. The request is registered and
//   presented to the selected slave until that slave acks. A decode miss
//   completes at once with an error.
//
// Parameters
//   NSLV   : number of slave ports (1..16)
//   DW     : data width (byte-select width DW/8)
//   TO_CYC : ACCESS cycles allowed before a timeout (>=2)
//
// Configuration macro
//   SOPC_BUS_TIMEOUT_EN : when defined, an ACCESS with no ack by the
//                         TO_CYC-th cycle ends in DONE with an error.
//                         Undefined: ACCESS waits indefinitely.
//
// Ports
//   clk, rst          : clock (rising edge), async active-low reset
//   cpu_*_i           : CPU request (ce, we, sel, addr, write data)
//   cpu_data_o        : read data, valid in DONE (zero on error or write)
//   cpu_stall_o       : cpu_ce_i AND (state != DONE)
//   cpu_err_o         : bus error, valid in DONE
//   slv_ce_o          : one-hot slave select
//   slv_we/sel/addr/data_o : registered request shared by all slaves
//   slv_data_i        : slave i read data at [i*DW +: DW]
//   slv_ack_i         : per-slave completion
//   err_cnt_o         : saturating bus-error count
//   err_int_o         : one-cycle error pulse, coincident with DONE
// ---------------------------------------------------------------------------
module sopc_bus_ctrl #(
   parameter int unsigned NSLV   = 4,
   parameter int unsigned DW     = 32,
   parameter int unsigned TO_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_ce_i,
   input  logic                 cpu_we_i,
   input  logic [DW/8-1:0]      cpu_sel_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [DW-1:0]        cpu_data_i,
   output logic [DW-1:0]        cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 cpu_err_o,
   output logic [NSLV-1:0]      slv_ce_o,
   output logic                 slv_we_o,
   output logic [DW/8-1:0]      slv_sel_o,
   output logic [31:0]          slv_addr_o,
   output logic [DW-1:0]        slv_data_o,
   input  logic [NSLV*DW-1:0]   slv_data_i,
   input  logic [NSLV-1:0]      slv_ack_i,
   output logic [7:0]           err_cnt_o,
   output logic                 err_int_o
);

   localparam int unsigned SW = DW / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [SW-1:0]     sel_q, sel_d;
   logic [31:0]       addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [NSLV-1:0]   ce_q, ce_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              err_int_q, err_int_d;

`ifdef SOPC_BUS_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TO_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`else
   // TO_CYC has no effect in this build.
   if (TO_CYC < 2) begin : g_to_cyc_unused
   end
`endif

   // Address decode
   logic [3:0]        slv_idx;
   logic              dec_hit;
   logic [NSLV-1:0]   dec_onehot;

   always_comb begin
      slv_idx    = cpu_addr_i[31:28];
      dec_hit    = (32'(slv_idx) < NSLV);
      dec_onehot = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (32'(slv_idx) == i) begin
            dec_onehot[i] = 1'b1;
         end
      end
   end

   // Only the selected slave's ack and data are visible; ce_q is one-hot
   // during ACCESS and all-zero otherwise, so stray acks are masked off.
   logic              ack_sel;
   logic [DW-1:0]     rdata_mux;

   always_comb begin
      ack_sel   = |(slv_ack_i & ce_q);
      rdata_mux = '0;
      for (int unsigned i = 0; i < NSLV; i++) begin
         if (ce_q[i]) begin
            rdata_mux = rdata_mux | slv_data_i[i*DW +: DW];
         end
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ce_d      = ce_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      err_int_d = 1'b0;
`ifdef SOPC_BUS_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cpu_ce_i) begin
               rdata_d = '0;
               if (dec_hit) begin
                  we_d    = cpu_we_i;
                  sel_d   = cpu_sel_i;
                  addr_d  = cpu_addr_i;
                  wdata_d = cpu_data_i;
                  ce_d    = dec_onehot;
                  err_d   = 1'b0;
`ifdef SOPC_BUS_TIMEOUT_EN
                  to_cnt_d = '0;
`endif
                  state_d = ST_ACCESS;
               end else begin
                  ce_d    = '0;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_ACCESS: begin
            // Ack is tested first so it beats a timeout in the same cycle.
            if (ack_sel) begin
               rdata_d = we_q ? '0 : rdata_mux;
               err_d   = 1'b0;
               ce_d    = '0;
               state_d = ST_DONE;
            end
`ifdef SOPC_BUS_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               ce_d    = '0;
               state_d = ST_DONE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            ce_d    = '0;
         end
      endcase

      // Error bookkeeping on entry to DONE
      if ((state_q != ST_DONE) && (state_d == ST_DONE) && err_d) begin
         err_int_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         we_q      <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ce_q      <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         err_int_q <= 1'b0;
`ifdef SOPC_BUS_TIMEOUT_EN
         to_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ce_q      <= ce_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         err_int_q <= err_int_d;
`ifdef SOPC_BUS_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
`endif
      end
   end

   // Outputs
   always_comb begin
      cpu_data_o  = (state_q == ST_DONE) ? rdata_q : '0;
      cpu_err_o   = (state_q == ST_DONE) && err_q;
      // Gated by rst so the stall drops immediately while reset is held.
      cpu_stall_o = rst && cpu_ce_i && (state_q != ST_DONE);
      slv_ce_o    = ce_q;
      slv_we_o    = we_q;
      slv_sel_o   = sel_q;
      slv_addr_o  = addr_q;
      slv_data_o  = wdata_q;
      err_cnt_o   = err_cnt_q;
      err_int_o   = err_int_q;
   end

endmodule

// File: tb/tb_sopc_bus_ctrl.sv
module tb_sopc_bus_ctrl;

   localparam int unsigned NSLV   = 4;
   localparam int unsigned DW     = 32;
   localparam int unsigned TO_CYC = 16;

   logic                clk;
   logic                rst;
   logic                cpu_ce_i;
   logic                cpu_we_i;
   logic [3:0]          cpu_sel_i;
   logic [31:0]         cpu_addr_i;
   logic [31:0]         cpu_data_i;
   logic [31:0]         cpu_data_o;
   logic                cpu_stall_o;
   logic                cpu_err_o;
   logic [NSLV-1:0]     slv_ce_o;
   logic                slv_we_o;
   logic [3:0]          slv_sel_o;
   logic [31:0]         slv_addr_o;
   logic [31:0]         slv_data_o;
   logic [NSLV*DW-1:0]  slv_data_i;
   logic [NSLV-1:0]     slv_ack_i;
   logic [7:0]          err_cnt_o;
   logic                err_int_o;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned exp_errs = 0;   // bus errors seen since the last reset

   sopc_bus_ctrl #(.NSLV(NSLV), .DW(DW), .TO_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
      .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o), .cpu_err_o(cpu_err_o),
      .slv_ce_o(slv_ce_o), .slv_we_o(slv_we_o), .slv_sel_o(slv_sel_o),
      .slv_addr_o(slv_addr_o), .slv_data_o(slv_data_o),
      .slv_data_i(slv_data_i), .slv_ack_i(slv_ack_i),
      .err_cnt_o(err_cnt_o), .err_int_o(err_int_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] sat_cnt(input int unsigned n);
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   task automatic scramble_slaves();
      for (int k = 0; k < NSLV; k++) slv_data_i[k*DW +: DW] = $urandom;
   endtask

   // Runs one transaction. Entry and exit at a negedge with the controller
   // in IDLE. Ack from the selected slave arrives in ACCESS cycle dly+1.
   task automatic do_txn(input logic [31:0] addr, input logic we,
                         input logic [3:0] sel, input logic [31:0] wd,
                         input int unsigned dly, input logic [31:0] rd);
      logic [3:0]      idx;
      bit              hit;
      logic [NSLV-1:0] oh;
      logic [NSLV-1:0] noise;
      logic [31:0]     exp_data;
      idx = addr[31:28];
      hit = (int'(idx) < NSLV);
      oh  = '0;
      if (hit) oh[idx] = 1'b1;
      exp_data = (hit && !we) ? rd : 32'h0;

      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_sel_i  = sel;
      cpu_addr_i = addr;
      cpu_data_i = wd;
      slv_ack_i  = '0;
      #1 chk("stall_req", 64'(cpu_stall_o), 64'd1);

      if (hit) begin
         for (int c = 0; c <= int'(dly); c++) begin
            @(negedge clk);
            chk("acc_ce",    64'(slv_ce_o),   64'(oh));
            chk("acc_addr",  64'(slv_addr_o), 64'(addr));
            chk("acc_we",    64'(slv_we_o),   64'(we));
            chk("acc_sel",   64'(slv_sel_o),  64'(sel));
            chk("acc_wdata", 64'(slv_data_o), 64'(wd));
            chk("acc_stall", 64'(cpu_stall_o), 64'd1);
            // Request inputs wander while the transaction is in flight.
            cpu_we_i   = 1'($urandom);
            cpu_sel_i  = 4'($urandom);
            cpu_addr_i = $urandom;
            cpu_data_i = $urandom;
            scramble_slaves();
            noise = 4'($urandom) & ~oh;
            if (c == int'(dly)) begin
               slv_ack_i = noise | oh;
               slv_data_i[idx*DW +: DW] = rd;
            end else begin
               slv_ack_i = noise;
            end
         end
      end else begin
         exp_errs++;
      end

      @(negedge clk);   // DONE
      chk("done_stall", 64'(cpu_stall_o), 64'd0);
      chk("done_data",  64'(cpu_data_o),  64'(exp_data));
      chk("done_err",   64'(cpu_err_o),   64'(!hit));
      chk("done_int",   64'(err_int_o),   64'(!hit));
      chk("done_ce",    64'(slv_ce_o),    64'd0);
      chk("err_cnt",    64'(err_cnt_o),   64'(sat_cnt(exp_errs)));
      // Stray acks and a pending hit request in DONE must not start anything.
      slv_ack_i  = 4'($urandom);
      cpu_addr_i = {4'($urandom_range(0, NSLV - 1)), 28'($urandom)};

      @(negedge clk);   // IDLE
      chk("idle_ce",    64'(slv_ce_o),    64'd0);
      chk("idle_int",   64'(err_int_o),   64'd0);
      chk("idle_stall", 64'(cpu_stall_o), 64'd1);
      chk("idle_err",   64'(cpu_err_o),   64'd0);
      cpu_ce_i  = 1'b0;
      slv_ack_i = '0;
   endtask

   initial begin
      logic [3:0]  ridx;
      int unsigned hold;
      rst        = 1'b0;
      cpu_ce_i   = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_sel_i  = '0;
      cpu_addr_i = '0;
      cpu_data_i = '0;
      slv_data_i = '0;
      slv_ack_i  = '0;

      repeat (3) @(negedge clk);
      chk("rst_ce",    64'(slv_ce_o),    64'd0);
      chk("rst_stall", 64'(cpu_stall_o), 64'd0);
      chk("rst_data",  64'(cpu_data_o),  64'd0);
      chk("rst_err",   64'(cpu_err_o),   64'd0);
      chk("rst_cnt",   64'(err_cnt_o),   64'd0);
      chk("rst_int",   64'(err_int_o),   64'd0);
      chk("rst_addr",  64'(slv_addr_o),  64'd0);

      // Request presented in the very first cycle out of reset; minimum latency read.
      rst = 1'b1;
      do_txn(32'h1000_0004, 1'b0, 4'hF, 32'h0, 0, 32'hDEAD_BEEF);
      // Write to slave 0 held for several cycles before the ack.
      do_txn(32'h0000_0010, 1'b1, 4'b0011, 32'h1234_5678, 3, 32'hCAFE_F00D);
      // Decode miss.
      do_txn(32'hF000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);

      // Random mix of hits and misses.
      for (int n = 0; n < 40; n++) begin
         ridx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(NSLV, 15))
                                            : 4'($urandom_range(0, NSLV - 1));
         do_txn({ridx, 28'($urandom)}, 1'($urandom), 4'($urandom), $urandom,
                $urandom_range(0, 4), $urandom);
      end

`ifdef SOPC_BUS_TIMEOUT_EN
      // Ack in the last allowed ACCESS cycle beats the timeout.
      do_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, TO_CYC - 1, 32'h5A5A_A5A5);
      // Slave 2 never acks: DONE after TO_CYC ACCESS cycles with an error.
      cpu_ce_i   = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 32'h2000_0000;
      for (int c = 0; c < int'(TO_CYC); c++) begin
         @(negedge clk);
         chk("to_stall", 64'(cpu_stall_o), 64'd1);
         chk("to_ce",    64'(slv_ce_o),    64'b0100);
         slv_ack_i = 4'($urandom) & 4'b1011;
      end
      exp_errs++;
      @(negedge clk);
      chk("to_err",  64'(cpu_err_o),   64'd1);
      chk("to_data", 64'(cpu_data_o),  64'd0);
      chk("to_int",  64'(err_int_o),   64'd1);
      chk("to_dstall", 64'(cpu_stall_o), 64'd0);
      chk("to_cnt",  64'(err_cnt_o),   64'(sat_cnt(exp_errs)));
      cpu_ce_i  = 1'b0;
      slv_ack_i = '0;
      @(negedge clk);
      hold = 5;
`else
      hold = 110;
`endif

      // Error counter saturation.
      for (int n = 0; n < 260; n++) begin
         do_txn({4'($urandom_range(NSLV, 15)), 28'($urandom)}, 1'b0, 4'hF, 32'h0, 0, 32'h0);
      end
      chk("sat_cnt", 64'(err_cnt_o), 64'd255);

      // Slave 2 never acks; stall persists, then reset lands mid-ACCESS.
      cpu_ce_i   = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 32'h2000_0000;
      for (int c = 0; c < int'(hold); c++) begin
         @(negedge clk);
         chk("hang_stall", 64'(cpu_stall_o), 64'd1);
         chk("hang_ce",    64'(slv_ce_o),    64'b0100);
         slv_ack_i = 4'($urandom) & 4'b1011;
      end
      #2 rst = 1'b0;
      #1;
      chk("arst_ce",    64'(slv_ce_o),    64'd0);
      chk("arst_stall", 64'(cpu_stall_o), 64'd0);
      chk("arst_cnt",   64'(err_cnt_o),   64'd0);
      chk("arst_addr",  64'(slv_addr_o),  64'd0);
      exp_errs = 0;
      slv_ack_i = '0;
      @(negedge clk);
      cpu_ce_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_txn(32'h0000_0008, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
